ln_arg_normalizer: RTL

- Upstream stage of the natural-log core.
- Accepts an unsigned Q16.16 operand and normalizes it to a Q0.16 mantissa in [0.5, 1) plus a signed power-of-two exponent: Din = Xbus * 2^Exp.
- Sequential leading-zero search: 4-bit coarse steps, then 1-bit fine steps.
- When done, pulses ln_start alongside Xbus so the log core can be launched directly; downstream logic adds Exp*ln2 to the log result.

---
 rtl/ln_pkg.sv | 26 ++
 rtl/ln_arg_normalizer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ln_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ln_pkg
// Brief    : Shared constants, Q-format defaults and FSM encoding for the
//            natural-log argument path.
// Revision : 1.0 - initial release
// ============================================================================
package ln_pkg;

    localparam int LN_XW = 16;   // log-core Xbus width
    localparam int LN_RW = 18;   // log-core result width

    localparam int LN_W  = 32;   // default operand width
    localparam int LN_IW = 16;   // default integer bits of the operand

    // ln(2) in Q0.LN_RW, used downstream to add Exp*ln2 to the log result
    localparam logic [LN_RW-1:0] LN2 = 18'd181704;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } ln_state_t;

endpackage : ln_pkg
`default_nettype wire

// File: rtl/ln_arg_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : ln_arg_normalizer
// Brief    : Normalizes an unsigned fixed-point operand to a [0.5,1) mantissa
//            and a signed power-of-two exponent, then launches the log core.
// Revision : 1.0 - initial release
// ============================================================================
module ln_arg_normalizer
    import ln_pkg::*;
#(
    parameter int W  = LN_W,
    parameter int IW = LN_IW,
    parameter int MW = LN_XW,
    parameter int EW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  Din,
    output logic [MW-1:0] Xbus,
    output logic [EW-1:0] Exp,
    output logic          Zero,
    output logic          ln_start,
    output logic          Ready,
    output logic          Busy
);

    localparam int CW = $clog2(W);
    localparam logic [EW-1:0] c_IW_E = EW'(IW);
    localparam logic [CW-1:0] c_COARSE = CW'(4);
    localparam logic [CW-1:0] c_FINE   = CW'(1);

    ln_state_t     r_state;
    logic [W-1:0]  r_sh;
    logic [CW-1:0] r_cnt;
    logic [MW-1:0] r_xbus;
    logic [EW-1:0] r_exp;
    logic          r_zero;
    logic          r_ln_start;
    logic          r_ready;
    logic          r_busy;

    logic          w_sh_zero;
    logic          w_msb;
    logic          w_nib_zero;
    logic [EW-1:0] w_exp;

    assign w_sh_zero  = (r_sh == '0);
    assign w_msb      = r_sh[W-1];
    assign w_nib_zero = (r_sh[W-1 -: 4] == 4'd0);
    // Exponent is the integer-bit count minus however far the operand moved left
    assign w_exp      = c_IW_E - EW'(r_cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_sh       <= '0;
            r_cnt      <= '0;
            r_xbus     <= '0;
            r_exp      <= '0;
            r_zero     <= 1'b0;
            r_ln_start <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ln_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sh    <= Din;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    if (w_sh_zero) begin
                        r_zero     <= 1'b1;
                        r_xbus     <= '0;
                        r_exp      <= '0;
                        r_ready    <= 1'b1;
                        r_ln_start <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= DONE;
                    end else if (w_msb) begin
                        r_zero     <= 1'b0;
                        r_xbus     <= r_sh[W-1 -: MW];
                        r_exp      <= w_exp;
                        r_ready    <= 1'b1;
                        r_ln_start <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= DONE;
                    end else if (w_nib_zero) begin
                        r_sh  <= r_sh << 4;
                        r_cnt <= r_cnt + c_COARSE;
                    end else begin
                        r_sh  <= r_sh << 1;
                        r_cnt <= r_cnt + c_FINE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Xbus     = r_xbus;
    assign Exp      = r_exp;
    assign Zero     = r_zero;
    assign ln_start = r_ln_start;
    assign Ready    = r_ready;
    assign Busy     = r_busy;

endmodule : ln_arg_normalizer
`default_nettype wire
